// File: rtl/rice_core_pkg.sv
// Shared RICE core CSR types: instruction operation encoding and the
// read-only address rule used by the CSR access unit.
package rice_core_pkg;

  localparam int unsigned RICE_RISCV_CSR_ADDRESS_WIDTH = 12;

  // Encoding 2'd3 is reserved and is rejected as an illegal instruction.
  typedef enum logic [1:0] {
    CSR_OP_RW = 2'd0,
    CSR_OP_RS = 2'd1,
    CSR_OP_RC = 2'd2
  } rice_core_csr_op;

  function automatic logic is_csr_read_only(input logic [11:0] address);
    return address[11:10] == 2'b11;
  endfunction

endpackage

// File: rtl/rice_core_csr_alu.sv
// Combinational CSR write-data computation: new value from op, old value and
// operand.
module rice_core_csr_alu
  import rice_core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  rice_core_csr_op   op_i,
  input  logic [XLEN-1:0]   old_i,
  input  logic [XLEN-1:0]   operand_i,
  output logic [XLEN-1:0]   new_o
);

  always_comb begin
    new_o = operand_i;
    case (op_i)
      CSR_OP_RS: new_o = old_i | operand_i;
      CSR_OP_RC: new_o = old_i & ~operand_i;
      default:   new_o = operand_i;
    endcase
  end

endmodule

// File: rtl/rice_core_csr_access.sv
// Execute-stage CSR read-modify-write unit driving the CSR slave bus.
// Optional response timeout: define RICE_CORE_CSR_ACCESS_TIMEOUT_EN.
module rice_core_csr_access
  import rice_core_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CSR_AW = RICE_RISCV_CSR_ADDRESS_WIDTH
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [1:0]        i_op,
  input  logic [CSR_AW-1:0] i_address,
  input  logic [XLEN-1:0]   i_operand,
  input  logic              i_rd_zero,
  input  logic              i_rs_zero,
  output logic              o_csr_request,
  input  logic              i_csr_ack,
  output logic              o_csr_write,
  output logic [CSR_AW-1:0] o_csr_address,
  output logic [XLEN-1:0]   o_csr_write_data,
  input  logic              i_csr_response_valid,
  input  logic [XLEN-1:0]   i_csr_read_data,
  input  logic              i_csr_error,
  output logic              o_done,
  output logic [XLEN-1:0]   o_read_data,
  output logic              o_illegal
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_WR_WAIT,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [CSR_AW-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   operand_q, operand_d;
  logic [XLEN-1:0]   old_q, old_d;
  logic              wr_needed_q, wr_needed_d;
  logic              err_q, err_d;
  logic              flushed_q, flushed_d;
  logic              done_q;
  logic [XLEN-1:0]   rdata_q;
  logic              illegal_q;
  logic [XLEN-1:0]   new_data;

  logic accept, req_rd, req_wr, req_illegal, timeout;

  assign accept      = i_valid && o_ready && !i_flush;
  assign req_rd      = (i_op != CSR_OP_RW) || !i_rd_zero;
  assign req_wr      = (i_op == CSR_OP_RW) || !i_rs_zero;
  assign req_illegal = (i_op == 2'd3) ||
                       (req_wr && is_csr_read_only(i_address[CSR_AW-1 -: 12]));

`ifdef RICE_CORE_CSR_ACCESS_TIMEOUT_EN
  // Fires on the 255th consecutive waiting cycle without a response.
  localparam logic [7:0] TIMEOUT_LAST = 8'd254;
  logic [7:0] cnt_q;

  assign timeout = (cnt_q == TIMEOUT_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (state_d != state_q) begin
      cnt_q <= '0;
    end else if (state_q == S_RD_WAIT || state_q == S_WR_WAIT) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  rice_core_csr_alu #(.XLEN(XLEN)) u_alu (
    .op_i      (rice_core_csr_op'(op_q)),
    .old_i     (old_q),
    .operand_i (operand_q),
    .new_o     (new_data)
  );

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so that no
    // path through the case leaves it unassigned and infers a latch.
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    operand_d   = operand_q;
    old_d       = old_q;
    wr_needed_d = wr_needed_q;
    err_d       = err_q;
    flushed_d   = flushed_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d        = i_op;
          addr_d      = i_address;
          operand_d   = i_operand;
          wr_needed_d = req_wr;
          old_d       = '0;
          err_d       = req_illegal;
          flushed_d   = 1'b0;
          if (req_illegal)  state_d = S_DONE;
          else if (req_rd)  state_d = S_RD_REQ;
          else              state_d = S_WR_REQ;
        end
      end
      S_RD_REQ, S_WR_REQ: begin
        // Once acked the slave owes a response, so the flush is deferred.
        if (i_csr_ack) begin
          state_d   = (state_q == S_RD_REQ) ? S_RD_WAIT : S_WR_WAIT;
          flushed_d = i_flush;
        end else if (i_flush) begin
          state_d = S_IDLE;
        end
      end
      S_RD_WAIT: begin
        flushed_d = flushed_q || i_flush;
        if (i_csr_response_valid) begin
          if (flushed_d) begin
            state_d = S_IDLE;
          end else if (i_csr_error) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            old_d   = i_csr_read_data;
            state_d = wr_needed_q ? S_WR_REQ : S_DONE;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = flushed_d ? S_IDLE : S_DONE;
        end
      end
      S_WR_WAIT: begin
        flushed_d = flushed_q || i_flush;
        if (i_csr_response_valid) begin
          err_d   = i_csr_error;
          state_d = flushed_d ? S_IDLE : S_DONE;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = flushed_d ? S_IDLE : S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments and cleared
  // asynchronously, so reset takes effect without waiting for a clock.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      addr_q      <= '0;
      operand_q   <= '0;
      old_q       <= '0;
      wr_needed_q <= 1'b0;
      err_q       <= 1'b0;
      flushed_q   <= 1'b0;
      done_q      <= 1'b0;
      rdata_q     <= '0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      operand_q   <= operand_d;
      old_q       <= old_d;
      wr_needed_q <= wr_needed_d;
      err_q       <= err_d;
      flushed_q   <= flushed_d;
      done_q      <= (state_q == S_DONE);
      if (state_q == S_DONE) begin
        rdata_q   <= err_q ? '0 : old_q;
        illegal_q <= err_q;
      end
    end
  end

  // Ready stays low through the completion pulse and returns the cycle after.
  assign o_ready          = (state_q == S_IDLE) && !done_q;
  assign o_csr_request    = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
  assign o_csr_write      = (state_q == S_WR_REQ);
  assign o_csr_address    = addr_q;
  assign o_csr_write_data = o_csr_write ? new_data : '0;
  assign o_done           = done_q;
  assign o_read_data      = rdata_q;
  assign o_illegal        = illegal_q;

endmodule

// File: doc/rice_core_csr_access.md
Name: rice_core_csr_access

Overview:
Execute-stage CSR instruction unit, directly upstream of rice_core_env's CSR slave port.
- Accepts one decoded CSRRW/CSRRS/CSRRC(I) operation from the pipeline.
- Performs the read-modify-write as separate non-posted read and write bus transactions on the CSR bus.
- Returns the old CSR value for rd, or flags an illegal-instruction exception.
- One operation in flight at a time; the pipeline stalls on o_ready.

Parameters:
XLEN, 32, data width of operand, read data and CSR bus data.
CSR_AW, 12, CSR address width (RICE_RISCV_CSR_ADDRESS_WIDTH).

Ports:
i_clk  input  1  clock
i_rst_n  input  1  reset, asynchronous, active-low
i_flush  input  1  pipeline flush; aborts the operation at the next bus-safe point
i_valid  input  1  operation request
o_ready  output  1  accepts i_valid when high
i_op  input  2  rice_core_csr_op: RW=0, RS=1, RC=2; 3 is reserved and illegal
i_address  input  CSR_AW  CSR address
i_operand  input  XLEN  rs1 value or zero-extended uimm
i_rd_zero  input  1  rd==x0
i_rs_zero  input  1  rs1==x0 / uimm==0
o_csr_request  output  1  bus request
i_csr_ack  input  1  request accepted
o_csr_write  output  1  1=write, 0=read
o_csr_address  output  CSR_AW  bus address
o_csr_write_data  output  XLEN  bus write data
i_csr_response_valid  input  1  response returned
i_csr_read_data  input  XLEN  response read data
i_csr_error  input  1  response error
o_done  output  1  one-cycle completion pulse
o_read_data  output  XLEN  old CSR value, valid with o_done
o_illegal  output  1  illegal-instruction exception, valid with o_done

Behaviour:
- Reset values: all outputs 0, except o_ready=1; state=IDLE.
- FSM states and transitions:
  - IDLE: o_ready=1. On i_valid, latch all inputs.
    - op==3, or write requested to a read-only address (address[11:10]==2'b11): go to DONE with illegal set; no bus access.
    - Otherwise, if read is needed, go to RD_REQ; else go to WR_REQ.
  - RD_REQ: o_csr_request=1, o_csr_write=0; hold until i_csr_ack, then go to RD_WAIT.
  - RD_WAIT: on i_csr_response_valid:
    - error: go to DONE with illegal set.
    - no error, write needed: capture i_csr_read_data into old, go to WR_REQ.
    - no error, no write: capture into old, go to DONE.
  - WR_REQ: o_csr_request=1, o_csr_write=1, o_csr_write_data=new; hold until ack, then go to WR_WAIT.
  - WR_WAIT: on response, go to DONE; illegal=i_csr_error.
  - DONE: o_done=1 for exactly one cycle, then go to IDLE.
- Read needed: op!=RW, or i_rd_zero==0.
- Write needed: op==RW, or i_rs_zero==0.
- Write data:
  - RW: operand.
  - RS: old|operand.
  - RC: old&~operand.
- Request and address are stable from assertion until ack (valid/ack rule). Response can arrive no earlier than the cycle after ack.
- o_read_data=old when not illegal, 0 when illegal; held until the next o_done.
- A write whose read failed is never issued. CSR state is therefore untouched on a read error.
- Flush handling:
  - IDLE, or RD_REQ/WR_REQ before ack: return to IDLE, no o_done.
  - After ack (RD_WAIT/WR_WAIT): complete the bus transaction, suppress o_done, then return to IDLE. Orphan responses never occur.
  - A flush on the same cycle as i_valid in IDLE wins; the request is not accepted.
- Back-to-back: o_ready falls the cycle after acceptance and rises again the cycle after the DONE pulse.
- Minimum latency with a zero-wait slave (ack same cycle, response next cycle):
  - Read-only: 4 cycles from accept to o_done.
  - RMW: 6 cycles.
- Reset mid-operation: immediate return to IDLE and all outputs to reset values.

Optional Feature:
- RICE_CORE_CSR_ACCESS_TIMEOUT_EN defined:
  - 8-bit counter clears on every state change and increments in RD_WAIT/WR_WAIT.
  - At 255 cycles without a response: go to DONE with illegal=1.
  - Any response arriving later is dropped while in IDLE.
- Undefined: no counter; the unit waits indefinitely.

Decomposition:
- rice_core_pkg: typedef rice_core_csr_op (RW/RS/RC) and function is_csr_read_only(address).
- FSM state enum stays local.
- Sub-module rice_core_csr_alu: combinational write-data computation (op, old, operand -> new). Reusable by a future multi-issue path.

Test Plan:
- CSRRW 0x340 operand 0xDEADBEEF, rd!=0, slave returns 0x12345678 -> read then write of 0xDEADBEEF; o_done with o_read_data=0x12345678, o_illegal=0.
- CSRRS 0x300 operand 0x8, rs_zero=0, old 0x1800 -> write 0x1808. CSRRC same operands -> write 0x1800. CSRRS with rs_zero=1 -> no write transaction.
- CSRRW 0xF14 (read-only) -> o_done 2 cycles after accept, o_illegal=1, zero bus requests. CSRRS 0xF14 with rs_zero=1 -> read only, legal.
- Read response error on 0x7C0 -> no write issued; o_illegal=1, o_read_data=0.
- i_flush asserted in RD_WAIT with response delayed 3 cycles -> response consumed, no o_done; next op is accepted cleanly.
- With TIMEOUT_EN: slave never responds -> o_done with o_illegal=1 exactly 256 cycles after entering RD_WAIT.
